// File: rtl/priority_index_decoder32.sv
// priority_index_decoder32
// Receive side of the priority-encoder link. Each accepted beat carries the
// index of one set bit; the beat flagged with in_last closes the frame and the
// rebuilt word plus its popcount are presented on a registered valid/ready port.
// While a word waits for the consumer the decoder refuses new beats.
//
// Build option: define PID_ORDER_CHECK_EN to add the ordering checker, which
// pulses err_order when an in-range index is not strictly below the previous
// in-range index of the same frame. Without it err_order is tied low.

module priority_index_decoder32 #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [IDX_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_range,
  output logic             err_order
);

  localparam int SEL_W = $clog2(WIDTH);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] mask_next;
  logic [IDX_W-1:0] count;
  logic [IDX_W-1:0] count_next;
  logic [WIDTH-1:0] word_next;
  logic [IDX_W-1:0] out_count_next;
  logic             valid_next;
  logic             err_range_next;

  // Beat decode: the range test uses the full index, the bit select only the
  // low bits, so an out-of-range index never aliases onto a real bit.
  logic             accept;
  logic             in_range;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] onehot;
  logic             already_set;
  logic             is_new;
  logic [WIDTH-1:0] merged_mask;
  logic [IDX_W-1:0] merged_count;

  assign in_ready     = (state == ACCUM);
  assign accept       = in_valid && in_ready;
  assign in_range     = (32'(in_idx) < 32'(WIDTH));
  assign sel          = in_idx[SEL_W-1:0];
  assign onehot       = in_range ? (WIDTH'(1) << sel) : '0;
  assign already_set  = |(mask & onehot);
  assign is_new       = in_range && !already_set;
  assign merged_mask  = mask | onehot;
  assign merged_count = (is_new && (count < IDX_W'(WIDTH))) ? count + IDX_W'(1) : count;

  // Next-state and next-output logic for the accumulate / hold handshake.
  always_comb begin
    state_next     = state;
    mask_next      = mask;
    count_next     = count;
    word_next      = out_word;
    out_count_next = out_count;
    valid_next     = out_valid;
    err_range_next = 1'b0;
    case (state)
      ACCUM: begin
        if (accept) begin
          err_range_next = !in_range;
          mask_next      = merged_mask;
          count_next     = merged_count;
          if (in_last) begin
            word_next      = merged_mask;
            out_count_next = merged_count;
            valid_next     = 1'b1;
            state_next     = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          mask_next  = '0;
          count_next = '0;
          valid_next = 1'b0;
          state_next = ACCUM;
        end
      end
      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  // State register and registered outputs; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      mask      <= '0;
      count     <= '0;
      out_word  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
      err_range <= 1'b0;
    end else begin
      state     <= state_next;
      mask      <= mask_next;
      count     <= count_next;
      out_word  <= word_next;
      out_count <= out_count_next;
      out_valid <= valid_next;
      err_range <= err_range_next;
    end
  end

`ifdef PID_ORDER_CHECK_EN
  // Ordering checker: remembers the last in-range index of the current frame.
  logic [SEL_W-1:0] prev_idx;
  logic             prev_valid;
  logic             order_viol;

  assign order_viol = accept && in_range && prev_valid && (sel >= prev_idx);

  // Track the previous in-range index and forget it when the frame closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_idx   <= '0;
      prev_valid <= 1'b0;
      err_order  <= 1'b0;
    end else begin
      err_order <= order_viol;
      if (accept && in_last) begin
        prev_valid <= 1'b0;
      end else if (accept && in_range) begin
        prev_idx   <= sel;
        prev_valid <= 1'b1;
      end
    end
  end
`else
  assign err_order = 1'b0;
`endif

endmodule

// File: tb/tb_priority_index_decoder32.sv
// Testbench for priority_index_decoder32: directed vector table, a full-frame
// saturation sequence, then randomized frames checked against a frame-level model.

module tb_priority_index_decoder32;

  localparam int WIDTH = 32;
  localparam int IDX_W = 6;
  localparam int NUM_FRAMES = 60;
`ifdef PID_ORDER_CHECK_EN
  localparam bit ORDER_EN = 1'b1;
`else
  localparam bit ORDER_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [IDX_W-1:0] in_idx;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] out_word;
  logic [IDX_W-1:0] out_count;
  logic             out_valid;
  logic             out_ready;
  logic             err_range;
  logic             err_order;

  int n_checks = 0;
  int n_fail   = 0;

  priority_index_decoder32 #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_idx    (in_idx),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_range (err_range),
    .err_order (err_order)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [5:0]  idx;
    logic        last;
    logic        ordy;
    logic        e_ready;
    logic        e_ovalid;
    logic [31:0] e_word;
    logic [5:0]  e_count;
    logic        e_erange;
    logic        e_eorder;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    int          count;
  } frame_t;

  vec_t   vecs[$];
  frame_t expq[$];
  int     exp_range = 0;
  int     exp_order = 0;
  int     got_range = 0;
  int     got_order = 0;
  int     received  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst       = v.rst;
    in_valid  = v.vld;
    in_idx    = v.idx;
    in_last   = v.last;
    out_ready = v.ordy;
  endtask

  task automatic sendBeat(input logic [5:0] idx, input logic last);
    int   waited;
    logic acc;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_idx   = idx;
    in_last  = last;
    acc      = 1'b0;
    waited   = 0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
      if (!acc && waited > 200) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL beat_accept_timeout: got no in_ready expected in_ready within 200 cycles");
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ord_pulses;
    rst = 1'b1; in_valid = 1'b0; in_idx = '0; in_last = 1'b0; out_ready = 1'b0;

    // rst vld idx last ordy | ready ovalid word count erange eorder
    vecs.push_back('{1, 0,  0, 0, 0, 1, 0, 32'h0000_0000, 0, 0, 0});
    vecs.push_back('{1, 0,  0, 0, 0, 1, 0, 32'h0000_0000, 0, 0, 0});
    vecs.push_back('{0, 0,  0, 0, 0, 1, 0, 32'h0000_0000, 0, 0, 0});
    vecs.push_back('{0, 1, 31, 0, 1, 1, 0, 32'h0000_0000, 0, 0, 0});
    vecs.push_back('{0, 1, 17, 0, 1, 1, 0, 32'h0000_0000, 0, 0, 0});
    vecs.push_back('{0, 1,  0, 1, 1, 0, 1, 32'h8002_0001, 3, 0, 0});
    vecs.push_back('{0, 0,  0, 0, 1, 1, 0, 32'h8002_0001, 3, 0, 0});
    vecs.push_back('{0, 1,  5, 1, 0, 0, 1, 32'h0000_0020, 1, 0, 0});
    vecs.push_back('{0, 0,  0, 0, 0, 0, 1, 32'h0000_0020, 1, 0, 0});
    vecs.push_back('{0, 1,  6, 0, 0, 0, 1, 32'h0000_0020, 1, 0, 0});
    vecs.push_back('{0, 0,  0, 0, 0, 0, 1, 32'h0000_0020, 1, 0, 0});
    vecs.push_back('{0, 0,  0, 0, 0, 0, 1, 32'h0000_0020, 1, 0, 0});
    vecs.push_back('{0, 0,  0, 0, 1, 1, 0, 32'h0000_0020, 1, 0, 0});
    vecs.push_back('{0, 1, 40, 0, 1, 1, 0, 32'h0000_0020, 1, 1, 0});
    vecs.push_back('{0, 1,  3, 1, 1, 0, 1, 32'h0000_0008, 1, 0, 0});
    vecs.push_back('{0, 0,  0, 0, 1, 1, 0, 32'h0000_0008, 1, 0, 0});
    vecs.push_back('{0, 1,  9, 0, 1, 1, 0, 32'h0000_0008, 1, 0, 0});
    vecs.push_back('{0, 1,  9, 0, 1, 1, 0, 32'h0000_0008, 1, 0, ORDER_EN});
    vecs.push_back('{0, 1,  2, 1, 1, 0, 1, 32'h0000_0204, 2, 0, 0});
    vecs.push_back('{0, 0,  0, 0, 1, 1, 0, 32'h0000_0204, 2, 0, 0});
    vecs.push_back('{0, 1, 12, 0, 0, 1, 0, 32'h0000_0204, 2, 0, 0});
    vecs.push_back('{0, 1,  7, 0, 0, 1, 0, 32'h0000_0204, 2, 0, 0});
    vecs.push_back('{1, 0,  0, 0, 0, 1, 0, 32'h0000_0000, 0, 0, 0});
    vecs.push_back('{0, 1,  1, 1, 0, 0, 1, 32'h0000_0002, 1, 0, 0});
    vecs.push_back('{0, 0,  0, 0, 1, 1, 0, 32'h0000_0002, 1, 0, 0});
    vecs.push_back('{0, 1, 50, 1, 0, 0, 1, 32'h0000_0000, 0, 1, 0});
    vecs.push_back('{0, 0,  0, 0, 1, 1, 0, 32'h0000_0000, 0, 0, 0});

    $display("[TB] directed vectors: %0d", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d.in_ready", i),  32'(in_ready),  32'(vecs[i].e_ready));
      checkOutput($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ovalid));
      checkOutput($sformatf("v%0d.out_word", i),  out_word,       vecs[i].e_word);
      checkOutput($sformatf("v%0d.out_count", i), 32'(out_count), 32'(vecs[i].e_count));
      checkOutput($sformatf("v%0d.err_range", i), 32'(err_range), 32'(vecs[i].e_erange));
      checkOutput($sformatf("v%0d.err_order", i), 32'(err_order), 32'(vecs[i].e_eorder));
    end

    // Full frame 31..0 then a duplicate 5 closes it: count saturates at 32.
    ord_pulses = 0;
    in_valid   = 1'b1;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      in_idx = 6'(i);
      @(posedge clk);
      #1;
      if (err_order) ord_pulses++;
    end
    in_idx  = 6'd5;
    in_last = 1'b1;
    @(posedge clk);
    #1;
    if (err_order) ord_pulses++;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("full.out_valid", 32'(out_valid), 32'd1);
    checkOutput("full.out_word", out_word, 32'hFFFF_FFFF);
    checkOutput("full.out_count", 32'(out_count), 32'd32);
    checkOutput("full.err_order_pulses", 32'(ord_pulses), ORDER_EN ? 32'd1 : 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("full.release_valid", 32'(out_valid), 32'd0);
    checkOutput("full.release_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // Randomized frames: driver and monitor run concurrently.
    fork
      begin
        for (int f = 0; f < NUM_FRAMES; f++) begin
          int          len;
          int          prev;
          int          idxs[$];
          logic [31:0] word;
          len  = $urandom_range(1, 6);
          word = '0;
          prev = -1;
          idxs.delete();
          for (int b = 0; b < len; b++) begin
            int idx;
            idx = $urandom_range(0, 39);
            idxs.push_back(idx);
            if (idx < WIDTH) begin
              if (prev >= 0 && idx >= prev) exp_order++;
              prev      = idx;
              word[idx] = 1'b1;
            end else begin
              exp_range++;
            end
          end
          expq.push_back('{word, $countones(word)});
          for (int b = 0; b < len; b++) begin
            sendBeat(6'(idxs[b]), (b == len - 1));
          end
        end
      end
      begin
        int cycles;
        cycles = 0;
        while (received < NUM_FRAMES && cycles < 20000) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          if (err_range) got_range++;
          if (err_order) got_order++;
          if (out_valid) begin
            if (expq.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("[TB] FAIL rand.unexpected_word: got %0h expected no output", out_word);
            end else begin
              checkOutput($sformatf("rand%0d.out_word", received), out_word, expq[0].word);
              checkOutput($sformatf("rand%0d.out_count", received), 32'(out_count), 32'(expq[0].count));
              if (out_ready) begin
                void'(expq.pop_front());
                received++;
              end
            end
          end
          @(posedge clk);
          #1;
          cycles++;
        end
        out_ready = 1'b0;
        checkOutput("rand.frames_received", 32'(received), 32'(NUM_FRAMES));
      end
    join

    checkOutput("rand.err_range_pulses", 32'(got_range), 32'(exp_range));
    checkOutput("rand.err_order_pulses", 32'(got_order), ORDER_EN ? 32'(exp_order) : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
